// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    // Loader progress through the image: count header, payload, then terminal states.
    typedef enum logic [1:0] {
        LD_LEN,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } loader_state_t;

    // Receiver framing phases for one 8N1 character.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // The word-count header is 4 bytes; instruction words are also 4 bytes.
    localparam int IMAGE_HDR_BYTES = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer and mid-bit sampling.
// Latency: rx_valid/rx_ferr pulse the cycle after the mid-stop-bit sample.
// Backpressure: none; a new start edge is accepted right after the stop sample.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state_q;
    rx_state_t     state_d;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;

    // Next-state logic: falling edge starts a frame, a high line at mid-start is a glitch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (rx_prev && !rx_s2) state_d = RX_START;
            RX_START: if (baud_cnt == HALF) state_d = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (baud_cnt == FULL && bit_idx == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (baud_cnt == FULL) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RX_IDLE;
        else     state_q <= state_d;
    end

    // Synchronizer, baud/bit counters, data shift and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;

            if (state_q == RX_IDLE || state_d != state_q || baud_cnt == FULL)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state_q == RX_DATA && baud_cnt == FULL) begin
                rx_byte <= {rx_s2, rx_byte[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end

            if (state_q == RX_STOP && baud_cnt == FULL) begin
                if (rx_s2) rx_valid <= 1'b1;
                else       rx_ferr  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: UART image (32-bit LE count + LE words) written to instruction memory.
// Latency: imem_we one cycle after a word's 4th byte; done/core_rst one cycle after last write.
// Backpressure: none; every received byte is consumed on arrival.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [1:0]  LAST_IDX  = 2'(IMAGE_HDR_BYTES - 1);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;
    loader_state_t state_q;
    loader_state_t state_d;
    logic [1:0]    byte_idx;
    logic [23:0]   byte_sr;
    logic [31:0]   remaining;
    logic [31:0]   assembled;
    logic          accepting;
    logic          last_byte;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    // The incoming byte completes the little-endian word with the three held bytes.
    assign assembled = {rx_byte, byte_sr};
    assign accepting = (state_q == LD_LEN) || (state_q == LD_DATA);
    assign last_byte = rx_valid && (byte_idx == LAST_IDX);

    // Next-state and status outputs; terminal states hold until reset.
    always_comb begin
        state_d    = state_q;
        core_rst   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state_q)
            LD_LEN: begin
                if (rx_ferr)
                    state_d = LD_ERR;
                else if (last_byte) begin
                    if (assembled == 32'd0)
                        state_d = LD_DONE;
                    else if ({1'b0, assembled} > MAX_WORDS)
                        state_d = LD_ERR;
                    else
                        state_d = LD_DATA;
                end
            end
            LD_DATA: begin
                if (rx_ferr)
                    state_d = LD_ERR;
                else if (imem_we && remaining == 32'd0)
                    state_d = LD_DONE;
            end
            LD_DONE: begin
                core_rst  = 1'b0;
                load_done = 1'b1;
            end
            LD_ERR: begin
                load_error = 1'b1;
            end
            default: state_d = LD_ERR;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= LD_LEN;
        else     state_q <= state_d;
    end

    // Byte assembly, count capture, write issue and post-write address advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= '0;
            byte_sr    <= '0;
            remaining  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we)
                imem_addr <= imem_addr + 1'b1;

            if (rx_valid && accepting) begin
                byte_idx <= byte_idx + 1'b1;
                byte_sr  <= {rx_byte, byte_sr[23:8]};
                if (last_byte) begin
                    if (state_q == LD_LEN) begin
                        remaining <= assembled;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_wdata <= assembled;
                        remaining  <= remaining - 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench: byte-level image model with a per-cycle output checker.
// Latency: write/done windows derived from each byte's serial stop-bit position.
// Backpressure: n/a; bytes are driven back-to-back or with random idle gaps.
module tb_uart_program_loader;

    localparam int CPB   = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            lo;
        int            hi;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          load_done;
    logic          load_error;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_error(load_error)
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Image model: bytes accepted so far, header count, terminal flags, expected writes.
    int          m_idx;
    logic [31:0] m_n;
    logic [31:0] m_word;
    bit          m_done;
    bit          m_err;
    int          done_lo;
    int          done_hi;
    wr_t         exp_q[$];
    wr_t         wlog[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_idx  = 0;
        m_n    = '0;
        m_word = '0;
        m_done = 0;
        m_err  = 0;
        exp_q.delete();
        wlog.delete();
    endtask

    // Interpret one byte of the image; s is the cycle its start bit begins.
    task automatic model_byte(input logic [7:0] b, input bit ok, input int s);
        int pos;
        int k;
        if (m_done || m_err) return;
        if (!ok) begin
            m_err = 1;
            return;
        end
        if (m_idx < 4) begin
            m_n[8*m_idx +: 8] = b;
            m_idx++;
            if (m_idx == 4) begin
                if (m_n == 32'd0) begin
                    m_done  = 1;
                    done_lo = s + 9*CPB + CPB/2;
                    done_hi = s + 10*CPB + 4;
                end else if (m_n > 32'(DEPTH)) begin
                    m_err = 1;
                end
            end
        end else begin
            pos = (m_idx - 4) % 4;
            k   = (m_idx - 4) / 4;
            m_word[8*pos +: 8] = b;
            m_idx++;
            if (pos == 3) begin
                exp_q.push_back('{AW'(k), m_word, s + 9*CPB + CPB/2, s + 10*CPB + 4});
                if (32'(k + 1) == m_n) m_done = 1;
            end
        end
    endtask

    // Drive one 8N1 character starting at the current negedge.
    task automatic send_byte(input logic [7:0] b, input bit ok = 1'b1);
        int s;
        s = cyc;
        model_byte(b, ok, s);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!ok) repeat (CPB) @(negedge clk);
    endtask

    task automatic gap(input int maxc);
        repeat ($urandom_range(0, maxc)) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int g);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            gap(g);
        end
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2*CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_error", load_error, 0);
        model_clear();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle(input string nm);
        repeat (3*CPB) @(negedge clk);
        chk({nm, "_load_done"}, load_done, m_done);
        chk({nm, "_load_error"}, load_error, m_err);
        chk({nm, "_core_rst"}, core_rst, !m_done);
        chk({nm, "_pending_writes"}, exp_q.size(), 0);
    endtask

    // Per-cycle checker of DUT outputs against the image model.
    initial begin
        bit            prev_we   = 0;
        bit            prev_done = 0;
        logic [AW-1:0] prev_addr = '0;
        wr_t           e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we   = 0;
                prev_done = 0;
            end else begin
                chk("core_rst_vs_done", core_rst, !load_done);
                if (load_error) chk("error_expected", load_error, m_err);
                if (load_done && !prev_done) begin
                    chk("done_expected", load_done, m_done);
                    if (m_n == 32'd0)
                        chk("done_n0_timing", (cyc >= done_lo && cyc <= done_hi), 1);
                    else
                        chk("done_after_last_we", prev_we, 1);
                end
                if (prev_we && m_done && m_n != 32'd0 && exp_q.size() == 0)
                    chk("done_follows_last_we", load_done, 1);
                if (prev_we) chk("addr_incr", imem_addr, AW'(prev_addr + 1'b1));
                if (imem_we) begin
                    wlog.push_back('{imem_addr, imem_wdata, cyc, cyc});
                    if (exp_q.size() == 0) begin
                        chk("spurious_we", imem_we, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("we_addr", imem_addr, e.addr);
                        chk("we_data", imem_wdata, e.data);
                        chk("we_timing", (cyc >= e.lo && cyc <= e.hi), 1);
                    end
                end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
                    chk("we_deadline", imem_we, 1);
                    void'(exp_q.pop_front());
                end
                prev_we   = imem_we;
                prev_addr = imem_addr;
                prev_done = load_done;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        rx  = 1'b1;
        rst = 1'b1;
        model_clear();
        @(negedge clk);

        // Two-word image.
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h00100513, 0);
        send_word(32'h00200593, 0);
        settle("two_word");
        chk("t1_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t1_addr0", wlog[0].addr, 0);
            chk("t1_data0", wlog[0].data, 32'h00100513);
            chk("t1_addr1", wlog[1].addr, 1);
            chk("t1_data1", wlog[1].data, 32'h00200593);
        end

        // Empty image.
        do_reset();
        send_word(32'd0, 5);
        settle("empty");
        chk("t2_nwrites", wlog.size(), 0);

        // Framing error on data byte 2 of word 0, then valid bytes are ignored.
        do_reset();
        send_word(32'd1, 3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        settle("ferr");
        chk("t3_nwrites", wlog.size(), 0);

        // Oversize image.
        do_reset();
        send_word(32'd17, 0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        settle("oversize");
        chk("t4_nwrites_17", wlog.size(), 0);

        // Full-depth image, back-to-back or short gaps.
        do_reset();
        send_word(32'(DEPTH), 2);
        for (int w = 0; w < DEPTH; w++) send_word($urandom, 2);
        settle("full_depth");
        chk("t4_nwrites_16", wlog.size(), 16);
        if (wlog.size() == 16) chk("t4_last_addr", wlog[15].addr, 15);

        // Start-bit glitches around a valid image.
        do_reset();
        glitch();
        send_word(32'd1, 0);
        glitch();
        send_byte(8'hA5);
        glitch();
        send_byte(8'h5A);
        send_byte(8'h3C);
        send_byte(8'hC3);
        settle("glitch");
        chk("t5_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) chk("t5_data", wlog[0].data, 32'hC33C5AA5);

        // Reset after 6 bytes, reload, then trailing bytes.
        do_reset();
        send_word(32'd3, 0);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        do_reset();
        send_word(32'd1, 4);
        send_word(32'hDEADBEEF, 4);
        settle("reload");
        chk("t6_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("t6_addr", wlog[0].addr, 0);
            chk("t6_data", wlog[0].data, 32'hDEADBEEF);
        end
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        settle("trailing");
        chk("t6_trailing_nwrites", wlog.size(), 1);

        // Random images with random inter-byte gaps.
        for (int img = 0; img < 4; img++) begin
            do_reset();
            n = 32'($urandom_range(1, DEPTH));
            send_word(n, 12);
            for (int w = 0; w < int'(n); w++) send_word($urandom, 12);
            settle("random");
            chk("rand_nwrites", wlog.size(), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time program loader for the pipelined core. Receives a program image over a UART serial line (8N1), assembles little-endian 32-bit words, and writes them sequentially into instruction memory through a single write port. The core is held in reset through `core_rst` until the full image is written, then released so fetch starts at word address 0.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit, minimum 4. The default is 50 MHz / 115200.
- `ADDR_WIDTH`, default 10: instruction-memory word-address width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, synchronous and active-high.
- `rx`  in  1  asynchronous UART serial input, idle high.
- `imem_we`  out  1  instruction-memory write enable, one-cycle pulse.
- `imem_addr`  out  ADDR_WIDTH  word address for the write.
- `imem_wdata`  out  32  assembled instruction word.
- `core_rst`  out  1  reset to the pipeline; high until the load completes.
- `load_done`  out  1  image fully written.
- `load_error`  out  1  sticky error (framing error or oversize image).

## Operation
- **Receiver:**
  - `rx` passes through a 2-FF synchronizer.
  - Start is detected on a high-to-low transition of the synchronized line.
  - After `CLKS_PER_BIT/2` cycles the line is re-sampled. If it is high, treat it as a glitch and return to idle.
  - Then sample 8 data bits (LSB first) and the stop bit, each `CLKS_PER_BIT` cycles apart.
  - On stop = 1, pulse `rx_valid` for one cycle with `rx_byte`.
  - On stop = 0, pulse `rx_ferr` instead and discard the byte.
- **Image format:**
  - 4 bytes of word count N, little-endian.
  - Then N words, 4 bytes each, little-endian (byte 0 goes to bits 7:0).
- **Loader FSM states:**
  - `LD_LEN`: collect 4 count bytes.
    - On the 4th byte: if N = 0, go to `LD_DONE`.
    - If N > 2^ADDR_WIDTH, go to `LD_ERR`.
    - Otherwise go to `LD_DATA`.
  - `LD_DATA`: shift bytes into a word register. On the 4th byte, issue a write, increment `imem_addr`, and decrement the remaining count. After the N-th word is written, go to `LD_DONE`.
  - `LD_DONE`: `core_rst` = 0 and `load_done` = 1. All further UART bytes are ignored. The block stays here until `rst`.
  - `LD_ERR`: `core_rst` = 1 and `load_error` = 1, held until `rst`.
  - An `rx_ferr` in `LD_LEN` or `LD_DATA` sends the FSM to `LD_ERR`.
- **Width rules:**
  - The count register is 32 bits.
  - `imem_addr` wraps naturally at 2^ADDR_WIDTH. With N = 2^ADDR_WIDTH, the last write lands at address all-ones and no wrapped write occurs.

## Timing
- **Reset values:**
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `core_rst` = 1, `load_done` = 0, `load_error` = 0.
  - FSM in `LD_LEN`, receiver idle, byte index 0.
- **Reset mid-frame or mid-image:** abandons the load completely. The next byte is treated as count byte 0.
- **`rx` to receiver:** the synchronizer adds 2 cycles.
- **`rx_valid`:** asserted in the cycle after the mid-stop-bit sample.
- **`imem_we`:** asserted exactly 1 cycle after the `rx_valid` of a word's 4th byte, with `imem_addr` and `imem_wdata` valid in that same cycle. `imem_addr` increments on the following cycle.
- **`core_rst` / `load_done`:** change in the cycle after the final `imem_we` (or after the 4th count byte when N = 0). `core_rst` deasserts in the same cycle `load_done` asserts.
- **Back-to-back frames:** the receiver accepts a new start edge immediately after the stop-bit sample, with no idle bit required. The loader logic must not stall this, so there is no backpressure path.

## Structure
- Package `loader_pkg` holds:
  - the `loader_state_t` enum (`LD_LEN`, `LD_DATA`, `LD_DONE`, `LD_ERR`);
  - the receiver state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`);
  - the constant `IMAGE_HDR_BYTES` = 4.
- Sub-module `uart_rx` (parameter `CLKS_PER_BIT`; ports `clk`, `rst`, `rx`, `rx_byte`, `rx_valid`, `rx_ferr`) contains the synchronizer, bit counter, and baud counter.
- `uart_program_loader` contains the loader FSM, byte assembly, and the address and count registers.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8 and `ADDR_WIDTH` = 4.
1. **Two-word image:** send bytes 02 00 00 00, 13 05 10 00, 93 05 20 00.
   - `imem_we` pulses twice: addr 0 with 0x00100513, then addr 1 with 0x00200593.
   - `core_rst` falls one cycle after the second write, and `load_done` = 1.
2. **Empty image:** send N = 0.
   - No `imem_we` occurs.
   - `load_done` rises, and `core_rst` falls, one cycle after count byte 3's `rx_valid`.
3. **Framing error:** drive stop bit = 0 on data byte 2 of word 0.
   - No write occurs. `load_error` = 1 and `core_rst` stays 1.
   - Subsequent valid bytes have no effect until `rst`.
4. **Oversize and full-depth images:**
   - N = 17: go to `LD_ERR` with no writes.
   - N = 16: 16 writes to addresses 0–15, then `load_done`.
5. **Start-bit glitch:** a 2-cycle low pulse on `rx` produces no `rx_valid`. A following valid byte 0xA5 is received correctly.
6. **Mid-load reset and trailing bytes:**
   - Assert `rst` after 6 bytes, then send a full 1-word image. The write goes to addr 0 with the new data.
   - Bytes sent after `load_done` cause no writes.
